// File: rtl/lzc_seq_scanner.sv
// Sequential leading-zero counter: scans the operand MSB-first one CHUNK per cycle
// and reports the leading-zero count (or all-zero) through a valid/ready handshake.
module lzc_seq_scanner #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CHUNK = 16,
    localparam int unsigned NCHUNK = WIDTH / CHUNK,
    localparam int unsigned COUNT = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [COUNT-1:0] out_count,
    output logic             out_zero,
    output logic             busy
);

    localparam int unsigned LVLS = $clog2(CHUNK);
    localparam int unsigned KW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

    if ((WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("lzc_seq_scanner: WIDTH must be a power of two");
    end
    if ((CHUNK & (CHUNK - 1)) != 0 || CHUNK < 2) begin : g_bad_chunk
        $error("lzc_seq_scanner: CHUNK must be a power of two and at least 2");
    end
    if (WIDTH < CHUNK) begin : g_bad_ratio
        $error("lzc_seq_scanner: WIDTH must be at least CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [KW-1:0]     k;
    logic [WIDTH-1:0]  data_q;
    logic [CHUNK-1:0]  chunk;
    logic              chunk_nz;
    logic [LVLS-1:0]   chunk_lz;

    // Binary-tree leading-zero count: leaf j is bit j; at each level the upper child wins
    // when nonzero, otherwise the lower child's count is offset by the upper child's span.
    function automatic logic [LVLS:0] chunk_lzc(input logic [CHUNK-1:0] c);
        logic            nz  [LVLS+1][CHUNK];
        logic [LVLS-1:0] cnt [LVLS+1][CHUNK];
        for (int j = 0; j < CHUNK; j++) begin
            nz[0][j]  = c[j];
            cnt[0][j] = '0;
        end
        for (int l = 1; l <= LVLS; l++) begin
            for (int j = 0; j < CHUNK / 2; j++) begin
                nz[l][j]  = nz[l-1][2*j+1] | nz[l-1][2*j];
                cnt[l][j] = nz[l-1][2*j+1] ? cnt[l-1][2*j+1]
                                           : (cnt[l-1][2*j] | LVLS'(1 << (l - 1)));
            end
        end
        return {nz[LVLS][0], cnt[LVLS][0]};
    endfunction

    // The operand register is shifted left after each zero chunk, so the current chunk is always on top.
    assign chunk = data_q[WIDTH-1 -: CHUNK];

    always_comb begin
        {chunk_nz, chunk_lz} = chunk_lzc(chunk);
    end

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            data_q    <= '0;
            out_count <= '0;
            out_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q <= in_data;
                        k      <= '0;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (chunk_nz) begin
                        out_count <= (COUNT'(k) << LVLS) | COUNT'(chunk_lz);
                        out_zero  <= 1'b0;
                        state     <= DONE;
                    end else if (k == K_LAST) begin
                        out_count <= '0;
                        out_zero  <= 1'b1;
                        state     <= DONE;
                    end else begin
                        k      <= k + KW'(1);
                        data_q <= data_q << CHUNK;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lzc_seq_scanner.sv
// Directed bench for lzc_seq_scanner (WIDTH=64, CHUNK=16) with a queue-based scoreboard.
module tb_lzc_seq_scanner;

    localparam int WIDTH  = 64;
    localparam int CHUNK  = 16;
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int COUNT  = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [COUNT-1:0] out_count;
    logic             out_zero;
    logic             busy;

    always #5 clk = ~clk;

    lzc_seq_scanner #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_zero  (out_zero),
        .busy      (busy)
    );

    typedef struct {
        logic [COUNT-1:0] cnt;
        logic             zero;
        int               lat;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    logic [COUNT-1:0] last_cnt;
    logic             last_zero;
    logic [WIDTH-1:0] ops [6];
    int               ai, cyc, acc_n, hs_n;
    logic             acc, hs;
    exp_t             e;

    // Reference: scan bits from the MSB down for the first one.
    function automatic exp_t model(input logic [WIDTH-1:0] d);
        exp_t r;
        r.cnt  = '0;
        r.zero = 1'b1;
        r.lat  = NCHUNK;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (d[i] && r.zero) begin
                r.cnt  = COUNT'(WIDTH - 1 - i);
                r.zero = 1'b0;
                r.lat  = (WIDTH - 1 - i) / CHUNK + 1;
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [WIDTH-1:0] d, input bit track);
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        if (track) sb.push_back(model(d));
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        check("busy_after_accept", 64'(busy), 64'd1);
        check("in_ready_in_scan", 64'(in_ready), 64'd0);
    endtask

    task automatic wait_result(input string tag);
        int   lat;
        exp_t x;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            check({tag, "_busy_scan"}, 64'(busy), 64'd1);
            tick();
            lat++;
        end
        check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_sb_size"}, 64'(sb.size()), 64'd1);
        if (sb.size() > 0) begin
            x = sb.pop_front();
            check({tag, "_latency"}, 64'(lat), 64'(x.lat));
            check({tag, "_count"}, 64'(out_count), 64'(x.cnt));
            check({tag, "_zero"}, 64'(out_zero), 64'(x.zero));
            last_cnt  = x.cnt;
            last_zero = x.zero;
        end
        check({tag, "_busy_done"}, 64'(busy), 64'd1);
        check({tag, "_in_ready_done"}, 64'(in_ready), 64'd0);
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_dropped"}, 64'(out_valid), 64'd0);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        check({tag, "_idle_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_count_held"}, 64'(out_count), 64'(last_cnt));
        check({tag, "_zero_held"}, 64'(out_zero), 64'(last_zero));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 64'hFFFF_0000_0000_0000;
        out_ready = 1'b0;
        tick();
        check("in_ready_in_reset", 64'(in_ready), 64'd0);
        tick();
        check("reset_busy", 64'(busy), 64'd0);
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_count", 64'(out_count), 64'd0);
        check("reset_out_zero", 64'(out_zero), 64'd0);

        accept(64'h8000_0000_0000_0000, 1'b1);
        wait_result("msb");
        release_result("msb");

        accept(64'h0000_0000_0001_0000, 1'b1);
        wait_result("bit16");
        release_result("bit16");

        accept(64'h0000_0000_0000_0000, 1'b1);
        wait_result("allzero");
        release_result("allzero");

        accept(64'h0000_0000_0000_0001, 1'b1);
        wait_result("lsb");
        release_result("lsb");

        // Reset while scanning chunk 1 abandons the operation.
        accept(64'h0000_0000_0001_0000, 1'b0);
        tick();
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_in_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midscan_rst_out_valid", 64'(out_valid), 64'd0);
        check("midscan_rst_out_count", 64'(out_count), 64'd0);
        check("midscan_rst_out_zero", 64'(out_zero), 64'd0);
        check("midscan_rst_busy", 64'(busy), 64'd0);
        check("midscan_rst_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("no_stale_result", 64'(out_valid), 64'd0);
        end

        // Result held under backpressure while a new operand waits.
        accept(64'h0000_0000_0001_0000, 1'b1);
        wait_result("hold");
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            in_data   = {$urandom, $urandom} | 64'h1;
            out_ready = 1'b0;
            tick();
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_out_count", 64'(out_count), 64'd47);
            check("hold_out_zero", 64'(out_zero), 64'd0);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_data   = 64'h00F0_0000_0000_0000;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hold_release_valid", 64'(out_valid), 64'd0);
        check("hold_release_in_ready", 64'(in_ready), 64'd1);
        check("hold_release_busy", 64'(busy), 64'd0);
        sb.push_back(model(in_data));
        tick();
        in_valid = 1'b0;
        check("post_hold_accept_busy", 64'(busy), 64'd1);
        wait_result("post_hold");
        release_result("post_hold");

        // Back-to-back mixed operands with the consumer always ready.
        ops[0] = 64'h8000_0000_0000_0000;
        ops[1] = 64'h0000_4000_0000_0000;
        ops[2] = 64'h0000_0000_0000_0100;
        ops[3] = 64'h0000_0000_0000_0000;
        ops[4] = 64'h0123_4567_89AB_CDEF;
        ops[5] = 64'h0000_0000_8000_0000;
        out_ready = 1'b1;
        ai  = 0;
        cyc = 0;
        while ((ai < 6 || sb.size() > 0) && cyc < 200) begin
            in_valid = (ai < 6);
            in_data  = (ai < 6) ? ops[ai] : '0;
            acc = in_valid && in_ready;
            hs  = out_valid && out_ready;
            if (acc) sb.push_back(model(ops[ai]));
            if (hs) begin
                check("b2b_sb_nonempty", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("b2b_count", 64'(out_count), 64'(e.cnt));
                    check("b2b_zero", 64'(out_zero), 64'(e.zero));
                end
            end
            tick();
            cyc++;
            if (acc) ai++;
        end
        in_valid = 1'b0;
        check("b2b_accepted", 64'(ai), 64'd6);
        check("b2b_drained", 64'(sb.size()), 64'd0);

        // Throughput: MSB-set operands complete one per three cycles.
        acc_n    = 0;
        hs_n     = 0;
        in_valid = 1'b1;
        in_data  = 64'h8000_0000_0000_0000;
        for (int i = 0; i < 30; i++) begin
            acc = in_valid && in_ready;
            hs  = out_valid && out_ready;
            if (acc) begin
                sb.push_back(model(in_data));
                acc_n++;
            end
            if (hs) begin
                hs_n++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("thru_count", 64'(out_count), 64'(e.cnt));
                end
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("thru_accepts", 64'(acc_n), 64'd10);
        check("thru_handshakes", 64'(hs_n), 64'd10);
        check("thru_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lzc_seq_scanner.md
LZC_SEQ_SCANNER -- requirements
Module: lzc_seq_scanner

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning the operand width; it is a power of two and at least CHUNK.
REQ-002 SHALL have parameter CHUNK, default 16, meaning the bits examined per scan cycle; it is a power of two and at least 2.
REQ-003 SHALL have derived parameters NCHUNK = WIDTH/CHUNK and COUNT = $clog2(WIDTH).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: operand offered.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept an operand.
REQ-008 SHALL have port in_data, input, WIDTH bits: operand; bit WIDTH-1 is the MSB.
REQ-009 SHALL have port out_valid, output, 1 bit: result available.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port out_count, output, COUNT bits: number of leading zeros of the operand.
REQ-012 SHALL have port out_zero, output, 1 bit: the operand was all zeros.
REQ-013 SHALL have port busy, output, 1 bit: an operation is in flight (state is not IDLE).

Function
REQ-014 SHALL implement an FSM with states IDLE, SCAN and DONE; only one operation is in flight at a time.
REQ-015 In IDLE with rst low, in_ready SHALL be 1; in SCAN and DONE, and in any cycle with rst high, in_ready SHALL be 0.
REQ-016 The accepting edge is any edge where in_valid=1 and in_ready=1; on it the block SHALL register in_data, set chunk index k=0 and go to SCAN. in_data is ignored at all other edges.
REQ-017 In SCAN, chunk k SHALL be in_data bits [WIDTH-1-k*CHUNK : WIDTH-(k+1)*CHUNK]. The block SHALL count its leading zeros lz (0..CHUNK-1) with a combinational log2-depth tree and produce a chunk-nonzero flag.
REQ-018 In SCAN, when chunk k is nonzero, the next edge SHALL register out_count = k*CHUNK + lz and out_zero = 0, then go to DONE.
REQ-019 In SCAN, when chunk k is zero and k = NCHUNK-1, the next edge SHALL register out_count = 0 and out_zero = 1, then go to DONE.
REQ-020 In SCAN, when chunk k is zero and k < NCHUNK-1, the next edge SHALL increment k and stay in SCAN; k never wraps.
REQ-021 out_valid SHALL be 1 only in DONE.
REQ-022 Latency SHALL be k+1 rising edges from the accepting edge to out_valid=1, where k is the index of the first nonzero chunk; an all-zero operand takes NCHUNK edges.
REQ-023 In DONE, out_count and out_zero SHALL stay stable while out_ready=0, for any number of cycles.
REQ-024 On an edge where out_valid=1 and out_ready=1, the block SHALL go to IDLE and drop out_valid.
REQ-025 The earliest next accept SHALL be the edge after the result handshake; there is no bypass from DONE to SCAN.
REQ-026 out_count and out_zero SHALL hold their last registered values outside DONE.
REQ-027 A WIDTH that is not a power of two, a CHUNK that is not a power of two, CHUNK<2, or WIDTH<CHUNK SHALL be an elaboration-time error.
REQ-028 WIDTH = CHUNK SHALL be legal: NCHUNK=1 and every operation finishes in one scan edge.

Reset
REQ-029 An edge with rst=1 SHALL force state=IDLE, k=0, out_valid=0, out_count=0, out_zero=0 and busy=0, overriding all handshakes on that edge.
REQ-030 A reset in SCAN or DONE SHALL abandon the operation; no result is presented afterwards.
REQ-031 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification (WIDTH=64, CHUNK=16)
REQ-032 Accept in_data=0x8000_0000_0000_0000 -> out_valid on the 1st edge after accept, out_count=0, out_zero=0.
REQ-033 Accept 0x0000_0000_0001_0000 -> out_valid on the 3rd edge, out_count=47, out_zero=0; busy=1 from the accept edge until the result handshake.
REQ-034 Accept 0x0000_0000_0000_0001 -> out_valid on the 4th edge, out_count=63. Accept 0 -> out_valid on the 4th edge, out_count=0, out_zero=1.
REQ-035 In DONE hold out_ready=0 for 5 cycles with in_valid=1 and new in_data -> outputs stable, in_ready=0, nothing accepted. Raise out_ready -> IDLE on the next edge, then the new operand is accepted on the following edge.
REQ-036 Assert rst for 1 cycle while in SCAN at k=1 -> next cycle IDLE, out_valid=0, out_count=0, in_ready=1; no stale result ever appears.
REQ-037 Hold out_ready=1 and drive back-to-back in_valid -> every handshake is counted, results arrive in order, and 0x8000_0000_0000_0000 operands complete one per 3 cycles.
